// File: rtl/pipeline_stage_elastic.sv
// Two-entry elastic pipeline stage (main + skid register) with full-throughput handshaking.
// Optional saturating bubble counter on bubble_count_o when PIPE_BUBBLE_COUNT_EN is defined.
module pipeline_stage_elastic #(
  parameter int N_BITS = 64,
  parameter logic [N_BITS-1:0] RESET_VALUE = '0,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [N_BITS-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [N_BITS-1:0] out_data_o
`ifdef PIPE_BUBBLE_COUNT_EN
  ,
  output logic [CNT_W-1:0]  bubble_count_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b10
  } state_t;

  state_t            state, state_next;
  logic [N_BITS-1:0] main_p0, skid_p0;
  logic              accept, drain;
  logic              load_main_in, load_main_skid, load_skid;

  // Handshake outputs come straight from the state register, so in_ready_o
  // never sees out_ready_i combinationally.
  assign in_ready_o  = (state == EMPTY) || (state == FULL);
  assign out_valid_o = (state == FULL) || (state == SKID);
  assign out_data_o  = main_p0;

  assign accept = in_valid_i & in_ready_o;
  assign drain  = out_valid_o & out_ready_i;

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_next   = FULL;
        end
      end
      FULL: begin
        if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          load_skid  = 1'b1;
          state_next = SKID;
        end else if (drain) begin
          state_next = EMPTY;
        end
      end
      SKID: begin
        if (drain) begin
          load_main_skid = 1'b1;
          state_next     = FULL;
        end
      end
      default: state_next = EMPTY;
    endcase
    // A redirect throws away everything, including a same-cycle accept.
    if (flush_i) begin
      state_next     = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // ---- data stage p0: main and skid registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      main_p0 <= RESET_VALUE;
      skid_p0 <= RESET_VALUE;
    end else begin
      if (load_main_in)        main_p0 <= in_data_i;
      else if (load_main_skid) main_p0 <= skid_p0;
      if (load_skid)           skid_p0 <= in_data_i;
    end
  end

`ifdef PIPE_BUBBLE_COUNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] bubble_cnt;

  always_ff @(posedge clk) begin
    if (reset)             bubble_cnt <= '0;
    else if (!out_valid_o) bubble_cnt <= sat_inc(bubble_cnt);
  end

  assign bubble_count_o = bubble_cnt;
`endif

endmodule
